// File: rtl/chacha_pio_pkg.sv
// Shared definitions for the ChaCha20 control PIO: register addresses, STATUS bit
// positions and the start-block handshake states.
package chacha_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_CMD      = 3'd1;
    localparam logic [2:0] ADDR_STATUS   = 3'd2;
    localparam logic [2:0] ADDR_IRQMASK  = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_TMO  = 2;
    localparam int STAT_OVR  = 3;

    typedef enum logic [1:0] {
        HS_IDLE = 2'd0,
        HS_REQ  = 2'd1,
        HS_REL  = 2'd2
    } hs_state_t;

endpackage

// File: rtl/chacha_pio_ctrl_out_if.sv
// Avalon-MM slave bus of the control PIO, bundled with master/slave modports.
interface chacha_pio_ctrl_out_if;
    // Zero-wait-state bus: a write is taken on every clk edge where chipselect is high
    // and write_n is low; readdata always reflects the address of the previous cycle.
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/chacha_pio_hs_fsm.sv
// Four-phase req/ack handshake with per-phase timeout; emits one-cycle done/tmo
// pulses on the edge where it returns to idle. State is exported for debug.
module chacha_pio_hs_fsm import chacha_pio_pkg::*; #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      start_i,
    input  logic      ack_i,
    output logic      req_o,
    output logic      done_o,
    output logic      tmo_o,
    output hs_state_t state_o
);

    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam int CW    = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    hs_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= HS_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_o  = 1'b0;
        tmo_o   = 1'b0;
        case (state_q)
            HS_IDLE: begin
                if (start_i) begin
                    state_d = HS_REQ;
                    cnt_d   = '0;
                end
            end
            HS_REQ: begin
                if (ack_i) begin
                    state_d = HS_REL;
                    cnt_d   = '0;
                end else if (TO_EN && cnt_q == CNT_LAST) begin
                    state_d = HS_IDLE;
                    tmo_o   = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HS_REL: begin
                if (!ack_i) begin
                    state_d = HS_IDLE;
                    done_o  = 1'b1;
                end else if (TO_EN && cnt_q == CNT_LAST) begin
                    state_d = HS_IDLE;
                    tmo_o   = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = HS_IDLE;
        endcase
    end

    // req is decoded straight from the state flop, so reset drops it asynchronously.
    assign req_o   = (state_q == HS_REQ);
    assign state_o = state_q;

endmodule

// File: rtl/chacha_pio_ctrl_out.sv
// Write-side control PIO for the ChaCha20 core: DATA/OUTSET/OUTCLEAR output port,
// start-block handshake and sticky STATUS. CHACHA_PIO_IRQ_EN adds IRQMASK and irq.
module chacha_pio_ctrl_out import chacha_pio_pkg::*; #(
    parameter int               WIDTH          = 2,
    parameter int               TIMEOUT_CYCLES = 1024,
    parameter logic [WIDTH-1:0] DATA_RESET     = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    chacha_pio_ctrl_out_if.slave    bus,
    output logic [WIDTH-1:0]        out_port,
    output logic                    req_out,
    input  logic                    ack_in
`ifdef CHACHA_PIO_IRQ_EN
    ,
    output logic                    irq
`endif
);

    logic             wr, start, busy, hs_done, hs_tmo;
    logic [31:0]      wd;
    logic             unused_wd;
    hs_state_t        hs_state;
    logic [WIDTH-1:0] data_q, data_d;
    logic [3:1]       flags_q, flags_d, set_vec, clr_vec;
    logic [31:0]      readdata_q, readdata_d;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign wd        = bus.writedata;
    assign unused_wd = ^wd;
    assign start     = wr && (bus.address == ADDR_CMD) && wd[0];
    assign busy      = (hs_state != HS_IDLE);

    chacha_pio_hs_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_hs_fsm (
        .clk     (clk),
        .reset_n (reset_n),
        .start_i (start),
        .ack_i   (ack_in),
        .req_o   (req_out),
        .done_o  (hs_done),
        .tmo_o   (hs_tmo),
        .state_o (hs_state)
    );

    always_comb begin
        data_d = data_q;
        if (wr) begin
            case (bus.address)
                ADDR_DATA:     data_d = wd[WIDTH-1:0];
                ADDR_OUTSET:   data_d = data_q | wd[WIDTH-1:0];
                ADDR_OUTCLEAR: data_d = data_q & ~wd[WIDTH-1:0];
                default:       data_d = data_q;
            endcase
        end
    end

    // Sticky flags: a set arriving in the same cycle as its W1C clear wins.
    always_comb begin
        set_vec           = '0;
        set_vec[STAT_DONE] = hs_done;
        set_vec[STAT_TMO]  = hs_tmo;
        set_vec[STAT_OVR]  = start & busy;
        clr_vec = (wr && bus.address == ADDR_STATUS) ? wd[3:1] : 3'b000;
        flags_d = (flags_q & ~clr_vec) | set_vec;
    end

`ifdef CHACHA_PIO_IRQ_EN
    logic [3:1] mask_q, mask_d;
    logic       irq_q, irq_d;

    assign mask_d = (wr && bus.address == ADDR_IRQMASK) ? wd[3:1] : mask_q;
    assign irq_d  = |(flags_q & mask_q);
    assign irq    = irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end
`endif

    always_comb begin
        readdata_d = '0;
        case (bus.address)
            ADDR_DATA:    readdata_d = 32'(data_q);
            ADDR_STATUS:  readdata_d = {28'd0, flags_q, busy};
`ifdef CHACHA_PIO_IRQ_EN
            ADDR_IRQMASK: readdata_d = {28'd0, mask_q, 1'b0};
`endif
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= DATA_RESET;
            flags_q    <= '0;
            readdata_q <= '0;
        end else begin
            data_q     <= data_d;
            flags_q    <= flags_d;
            readdata_q <= readdata_d;
        end
    end

    assign out_port     = data_q;
    assign bus.readdata = readdata_q;

endmodule
